// File: rtl/mem_dump_reader_pkg.sv
// Shared types and constants for the memory dump reader.
package mem_dump_reader_pkg;

  // Dump sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  // Terminator word appended by the program loader
  localparam logic [31:0] SENTINEL_DEFAULT = 32'hFFFF_0000;

  // Mem4K port-A write-enable levels (read = deasserted)
  localparam logic MM_ENB_R = 1'b0;
  localparam logic MM_ENB_W = 1'b1;

  // Next word address inside the memory window; mask carries the size
  function automatic logic [31:0] wrap_next(input logic [31:0] addr,
                                            input logic [31:0] mask);
    return (addr + 32'd4) & mask;
  endfunction

endpackage

// File: rtl/mem_dump_reader_if.sv
// Word stream carrying dumped memory contents with their byte addresses.
interface mem_dump_reader_if;

  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic        o_last;

  modport master (
    output o_valid,
    output o_addr,
    output o_data,
    output o_last,
    input  o_ready
  );

  modport slave (
    input  o_valid,
    input  o_addr,
    input  o_data,
    input  o_last,
    output o_ready
  );

endinterface

// File: rtl/mem_dump_reader.sv
// Walks Mem4K port A one word at a time and streams each word out with its
// byte address, stopping on a word limit or on the loader's terminator.
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int          MEM_BYTES = 4096,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] SENTINEL  = SENTINEL_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               base_addr,
  input  logic [15:0]               max_words,
  input  logic                      stop_on_sent,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               words_read,
  output logic                      mem_enwr,
  output logic [31:0]               mem_abus,
  input  logic [31:0]               mem_dbusr,
  mem_dump_reader_if.master         st
);

  // Word-aligned address window; wrapping falls out of the mask
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1) & ~32'd3;
  // Wait-counter value on the last WT cycle (unused when RD_LAT is 0)
  localparam logic [1:0]  WT_LAST   = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] oaddr_q;
  logic [15:0] max_q;
  logic [15:0] wr_q;
  logic        sos_q;
  logic [1:0]  wcnt_q;
  logic        capture;
  logic        hs;
  logic        last_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus capture/handshake strobes
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    hs      = 1'b0;
    // Sentinel and limit may coincide; either one ends the dump on this word
    last_c  = ((wr_q + 16'd1) == max_q) || (sos_q && (data_q == SENTINEL));
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (max_words == 16'd0) ? ST_FIN : ST_RD;
      end
      ST_RD: begin
        if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end else begin
          state_d = ST_WT;
        end
      end
      ST_WT: begin
        if (wcnt_q == WT_LAST) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (st.o_ready) begin
          hs      = 1'b1;
          state_d = last_c ? ST_FIN : ST_RD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address walk, read-data capture and word accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      max_q   <= '0;
      wr_q    <= '0;
      sos_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        max_q <= max_words;
        sos_q <= stop_on_sent;
        wr_q  <= '0;
        // An empty dump must leave the memory address bus untouched
        if (max_words != 16'd0) addr_q <= base_addr & ADDR_MASK;
      end
      if (state_q == ST_RD)      wcnt_q <= '0;
      else if (state_q == ST_WT) wcnt_q <= wcnt_q + 2'd1;
      if (capture) begin
        data_q  <= mem_dbusr;
        oaddr_q <= addr_q;
      end
      if (hs) begin
        wr_q <= wr_q + 16'd1;
        // Only advance when another read follows, so the bus never shows
        // an address past the end of the dump
        if (!last_c) addr_q <= wrap_next(addr_q, ADDR_MASK);
      end
    end
  end

  assign busy       = (state_q == ST_RD) || (state_q == ST_WT) || (state_q == ST_OUT);
  assign done       = (state_q == ST_FIN);
  assign words_read = wr_q;
  assign mem_enwr   = MM_ENB_R;
  assign mem_abus   = addr_q;
  assign st.o_valid = (state_q == ST_OUT);
  assign st.o_last  = (state_q == ST_OUT) && last_c;
  assign st.o_data  = data_q;
  assign st.o_addr  = oaddr_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a scoreboard of expected beats.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] max_words;
  logic        stop_on_sent;
  logic        busy;
  logic        done;
  logic [15:0] words_read;
  logic        mem_enwr;
  logic [31:0] mem_abus;
  logic [31:0] mem_dbusr;

  mem_dump_reader_if sif ();

  mem_dump_reader #(
    .MEM_BYTES (4096),
    .RD_LAT    (1),
    .SENTINEL  (32'hFFFF_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .max_words    (max_words),
    .stop_on_sent (stop_on_sent),
    .busy         (busy),
    .done         (done),
    .words_read   (words_read),
    .mem_enwr     (mem_enwr),
    .mem_abus     (mem_abus),
    .mem_dbusr    (mem_dbusr),
    .st           (sif)
  );

  always #5 clk = ~clk;

  // Memory model with one cycle of read latency
  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  always @(posedge clk) rd_q <= mem[mem_abus[11:2]];
  assign mem_dbusr = rd_q;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  int   dones  = 0;
  int   vcnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic l);
    exp_t e;
    e.a = a;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  // Stream monitor: compares each accepted beat against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (sif.o_valid) vcnt++;
      if (sif.o_valid && sif.o_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("beat_addr", sif.o_addr, mon_e.a);
          check("beat_data", sif.o_data, mon_e.d);
          check("beat_last", 32'(sif.o_last), 32'(mon_e.l));
        end
        beats++;
      end
      if (done) dones++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] m, input logic s);
    base_addr    = b;
    max_words    = m;
    stop_on_sent = s;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    tick();
  endtask

  int b0, d0, v0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[512]  = 32'h0000_0011;
    mem[513]  = 32'h0000_0022;
    mem[514]  = 32'hFFFF_0000;
    mem[1022] = 32'h0000_00A1;
    mem[1023] = 32'h0000_00A2;
    mem[0]    = 32'h0000_00A3;
    rst = 1'b1; start = 1'b0; base_addr = '0; max_words = '0; stop_on_sent = 1'b0;
    sif.o_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_valid", 32'(sif.o_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_last",  32'(sif.o_last), 32'd0);
    check("rst_wr",    32'(words_read), 32'd0);
    check("rst_oaddr", sif.o_addr, 32'd0);
    check("rst_odata", sif.o_data, 32'd0);
    check("rst_abus",  mem_abus, 32'd0);
    rst = 1'b0;
    tick();

    // Sentinel-terminated dump
    b0 = beats; d0 = dones;
    push(32'd2048, 32'h11, 1'b0);
    push(32'd2052, 32'h22, 1'b0);
    push(32'd2056, 32'hFFFF_0000, 1'b1);
    pulse_start(32'd2048, 16'd100, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(60);
    check("t1_beats", 32'(beats - b0), 32'd3);
    check("t1_wr",    32'(words_read), 32'd3);
    check("t1_dones", 32'(dones - d0), 32'd1);
    check("t1_sb",    32'(sb.size()), 32'd0);

    // Word-limit dump ignoring the sentinel
    b0 = beats; d0 = dones;
    push(32'd2048, 32'h11, 1'b0);
    push(32'd2052, 32'h22, 1'b1);
    pulse_start(32'd2048, 16'd2, 1'b0);
    wait_done(60);
    check("t2_beats", 32'(beats - b0), 32'd2);
    check("t2_wr",    32'(words_read), 32'd2);
    check("t2_dones", 32'(dones - d0), 32'd1);
    check("t2_abus",  mem_abus, 32'd2052);

    // Empty dump
    b0 = beats; d0 = dones; v0 = vcnt;
    pulse_start(32'd1000, 16'd0, 1'b1);
    check("t3_done",  32'(done), 32'd1);
    check("t3_busy",  32'(busy), 32'd0);
    tick();
    check("t3_done_off", 32'(done), 32'd0);
    check("t3_abus",  mem_abus, 32'd2052);
    check("t3_wr",    32'(words_read), 32'd0);
    check("t3_valid", 32'(vcnt - v0), 32'd0);
    check("t3_dones", 32'(dones - d0), 32'd1);

    // Address wrap at the top of memory and first-beat latency
    b0 = beats;
    push(32'd4088, 32'hA1, 1'b0);
    push(32'd4092, 32'hA2, 1'b0);
    push(32'd0,    32'hA3, 1'b1);
    pulse_start(32'd4088, 16'd3, 1'b1);
    check("t4_valid_c1", 32'(sif.o_valid), 32'd0);
    tick();
    check("t4_valid_c2", 32'(sif.o_valid), 32'd0);
    tick();
    check("t4_valid_c3", 32'(sif.o_valid), 32'd1);
    wait_done(60);
    check("t4_beats", 32'(beats - b0), 32'd3);
    check("t4_wr",    32'(words_read), 32'd3);

    // Consumer stall with a start pulse that must be ignored
    b0 = beats;
    sif.o_ready = 1'b0;
    push(32'd2048, 32'h11, 1'b0);
    push(32'd2052, 32'h22, 1'b0);
    push(32'd2056, 32'hFFFF_0000, 1'b1);
    pulse_start(32'd2048, 16'd3, 1'b0);
    for (int n = 0; n < 10 && !sif.o_valid; n++) tick();
    for (int i = 0; i < 10; i++) begin
      check("t5_valid", 32'(sif.o_valid), 32'd1);
      check("t5_data",  sif.o_data, 32'h11);
      check("t5_addr",  sif.o_addr, 32'd2048);
      check("t5_abus",  mem_abus, 32'd2048);
      if (i == 4) begin
        base_addr = 32'd0; max_words = 16'd1; stop_on_sent = 1'b1; start = 1'b1;
      end
      if (i == 5) start = 1'b0;
      tick();
    end
    sif.o_ready = 1'b1;
    wait_done(60);
    check("t5_beats", 32'(beats - b0), 32'd3);
    check("t5_wr",    32'(words_read), 32'd3);

    // Reset in the middle of the second read
    b0 = beats; d0 = dones;
    push(32'd2048, 32'h11, 1'b0);
    push(32'd2052, 32'h22, 1'b0);
    push(32'd2056, 32'hFFFF_0000, 1'b1);
    pulse_start(32'd2048, 16'd3, 1'b0);
    tick(); tick(); tick(); tick();
    check("t6_pre_busy",  32'(busy), 32'd1);
    check("t6_pre_valid", 32'(sif.o_valid), 32'd0);
    rst = 1'b1;
    tick();
    check("t6_valid", 32'(sif.o_valid), 32'd0);
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_wr",    32'(words_read), 32'd0);
    check("t6_done",  32'(done), 32'd0);
    rst = 1'b0;
    sb.delete();
    tick();
    check("t6_done2", 32'(done), 32'd0);
    check("t6_dones", 32'(dones - d0), 32'd0);
    check("t6_beats", 32'(beats - b0), 32'd1);
    b0 = beats;
    push(32'd2048, 32'h11, 1'b1);
    pulse_start(32'd2048, 16'd1, 1'b0);
    wait_done(60);
    check("t6_re_beats", 32'(beats - b0), 32'd1);
    check("t6_re_wr",    32'(words_read), 32'd1);
    check("t6_re_sb",    32'(sb.size()), 32'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
